// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: the EX-side request/result signals and the multiplier/divider handshake for muldiv_ctrl.
interface muldiv_ctrl_if;
    logic        flush;
    logic        hold;
    logic        op_valid;
    logic [1:0]  op_sel;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic        mul_signed;
    logic [63:0] mul_result;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_start;
    logic        div_signed;
    logic        div_annul;
    logic        div_ready;
    logic [63:0] div_result;
    logic        stallreq;
    logic        res_valid;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    modport master (
        input  flush, hold, op_valid, op_sel, src1, src2, mul_result, div_ready, div_result,
        output mul_ina, mul_inb, mul_signed, div_opdata1, div_opdata2, div_start, div_signed,
               div_annul, stallreq, res_valid, hi_wdata, lo_wdata
    );
    modport slave (
        output flush, hold, op_valid, op_sel, src1, src2, mul_result, div_ready, div_result,
        input  mul_ina, mul_inb, mul_signed, div_opdata1, div_opdata2, div_start, div_signed,
               div_annul, stallreq, res_valid, hi_wdata, lo_wdata
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for mul/mulu/div/divu with stall, flush and hold handling.
// Defining DIV_ZERO_BYPASS_EN short-circuits divide-by-zero straight to DONE.
module muldiv_ctrl #(
    parameter int MUL_LAT = 1
) (
    input logic           clk,
    input logic           rst,
    muldiv_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_BUSY, DONE} state_t;
    state_t      state, state_nx;
    logic [31:0] op_a, op_b, hi, lo, hi_nx, lo_nx;
    logic [1:0]  op;
    logic [2:0]  cnt, cnt_nx;
    logic        accept, byp, stallreq, div_start, div_annul;
    assign accept = state == IDLE && bus.op_valid && !bus.flush && !rst;
`ifdef DIV_ZERO_BYPASS_EN
    assign byp = bus.op_sel[1] && bus.src2 == 32'd0;
`else
    assign byp = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            op    <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
            if (accept) begin
                op_a <= bus.src1;
                op_b <= bus.src2;
                op   <= bus.op_sel;
            end
        end
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        hi_nx     = hi;
        lo_nx     = lo;
        stallreq  = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;
        if (rst || bus.flush) begin
            state_nx  = IDLE;
            div_annul = state == DIV_BUSY;
        end else begin
            case (state)
                IDLE: if (bus.op_valid) begin
                    stallreq = 1'b1;
                    cnt_nx   = 3'(MUL_LAT - 1);
                    state_nx = byp ? DONE : bus.op_sel[1] ? DIV_BUSY : MUL_WAIT;
                    if (byp) {hi_nx, lo_nx} = {bus.src1, 32'hFFFF_FFFF};
                end
                MUL_WAIT: begin
                    stallreq = 1'b1;
                    cnt_nx   = cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        {hi_nx, lo_nx} = bus.mul_result;
                        cnt_nx         = 3'd0;
                        state_nx       = DONE;
                    end
                end
                DIV_BUSY: begin
                    stallreq  = 1'b1;
                    div_start = !bus.div_ready;
                    if (bus.div_ready) begin
                        {hi_nx, lo_nx} = bus.div_result;
                        state_nx       = DONE;
                    end
                end
                default: if (!bus.hold) state_nx = IDLE;
            endcase
        end
    end
    assign bus.mul_ina     = op_a;
    assign bus.mul_inb     = op_b;
    assign bus.mul_signed  = op[0];
    assign bus.div_opdata1 = op_a;
    assign bus.div_opdata2 = op_b;
    assign bus.div_signed  = op[0];
    assign bus.div_start   = div_start;
    assign bus.div_annul   = div_annul;
    assign bus.stallreq    = stallreq;
    // Result is only presented while DONE; zero otherwise so MEM never sees stale data.
    assign bus.res_valid   = state == DONE;
    assign bus.hi_wdata    = state == DONE ? hi : 32'd0;
    assign bus.lo_wdata    = state == DONE ? lo : 32'd0;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vector table plus hand sequences for hold, flush and mid-op reset.
module tb_muldiv_ctrl;
    localparam int DIV_CYC = 33;
    localparam int MS = 2;
    localparam int DS = 35;
`ifdef DIV_ZERO_BYPASS_EN
    localparam int ZS = 1;
    localparam int ZST = 0;
`else
    localparam int ZS = DS;
    localparam int ZST = DIV_CYC;
`endif
    typedef struct {
        logic [1:0]  sel;
        logic [31:0] a, b, hi, lo;
        int          stall, starts;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   dcnt = 0;
    vec_t v[8];
    muldiv_ctrl_if bus();
    muldiv_ctrl #(.MUL_LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [63:0] ext(input logic [31:0] x, input logic s);
        return {{32{s & x[31]}}, x};
    endfunction
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction
    assign bus.mul_result = ext(bus.mul_ina, bus.mul_signed) * ext(bus.mul_inb, bus.mul_signed);
    assign bus.div_result = div_model(bus.div_opdata1, bus.div_opdata2, bus.div_signed);
    assign bus.div_ready  = dcnt == DIV_CYC;
    always @(posedge clk) dcnt <= bus.div_start ? dcnt + 1 : 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic run_op(input vec_t t, output int stall, output int starts, output logic [63:0] res, output bit got);
        stall  = 0;
        starts = 0;
        res    = '0;
        got    = 1'b0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_sel   = t.sel;
        bus.src1     = t.a;
        bus.src2     = t.b;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            if (bus.res_valid) begin
                got = 1'b1;
                res = {bus.hi_wdata, bus.lo_wdata};
            end else begin
                stall  += int'(bus.stallreq);
                starts += int'(bus.div_start);
                @(negedge clk);
                bus.op_valid = 1'b0;
                bus.src1     = ~t.a;
                bus.src2     = 32'hDEAD_BEEF;
            end
        end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        int          st, sr;
        logic [63:0] res;
        bit          got, seen;
        v[0] = '{2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MS, 0};
        v[1] = '{2'b00, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MS, 0};
        v[2] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, MS, 0};
        v[3] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MS, 0};
        v[4] = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, DS, DIV_CYC};
        v[5] = '{2'b11, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, DS, DIV_CYC};
        v[6] = '{2'b10, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, DS, DIV_CYC};
        v[7] = '{2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, ZS, ZST};
        bus.flush    = 1'b0;
        bus.hold     = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_sel   = 2'b00;
        bus.src1     = 32'd9;
        bus.src2     = 32'd9;
        #2 rst = 1'b1;
        #1;
        chk("rst_ctl", {bus.stallreq, bus.res_valid, bus.div_start, bus.div_annul}, 0);
        chk("rst_hilo", {bus.hi_wdata, bus.lo_wdata}, 0);
        chk("rst_ops", {bus.mul_ina, bus.mul_inb}, 0);
        bus.op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_op(v[i], st, sr, res, got);
            chk($sformatf("v%0d_done", i), 64'(got), 1);
            chk($sformatf("v%0d_hilo", i), res, {v[i].hi, v[i].lo});
            chk($sformatf("v%0d_stall", i), 64'(st), 64'(v[i].stall));
            chk($sformatf("v%0d_starts", i), 64'(sr), 64'(v[i].starts));
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_after", i), {bus.res_valid, bus.stallreq, bus.hi_wdata, bus.lo_wdata}, 0);
        end
        bus.hold = 1'b1;
        run_op('{2'b01, 32'd7, 32'd6, 32'd0, 32'd42, MS, 0}, st, sr, res, got);
        chk("hold_c1", {63'(got), bus.res_valid}, 3);
        chk("hold_c1_hilo", res, 64'd42);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            bus.op_valid = 1'b1;
            #1;
            chk($sformatf("hold_c%0d", k), {bus.res_valid, bus.hi_wdata, bus.lo_wdata}, {1'b1, 64'd42});
            chk($sformatf("hold_c%0d_noacc", k), bus.stallreq, 0);
        end
        @(negedge clk);
        bus.hold     = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        chk("hold_release", {bus.res_valid, bus.lo_wdata}, {1'b1, 32'd42});
        @(negedge clk);
        #1;
        chk("hold_idle", {bus.res_valid, bus.stallreq, bus.lo_wdata}, 0);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_sel   = 2'b10;
        bus.src1     = 32'd100;
        bus.src2     = 32'd7;
        @(negedge clk);
        bus.op_valid = 1'b0;
        #1;
        chk("busy1_start", {bus.stallreq, bus.div_start, bus.div_annul}, 3'b110);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_annul", bus.div_annul, 1);
        chk("flush_stall", {bus.stallreq, bus.div_start}, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("flush_next", {bus.stallreq, bus.div_annul, bus.div_start, bus.res_valid}, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            seen |= bus.res_valid | bus.div_start;
        end
        chk("flush_no_valid", seen, 0);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.op_sel   = 2'b00;
        #1;
        chk("idle_flush_stall", bus.stallreq, 0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        chk("idle_flush_noacc", {bus.stallreq, bus.res_valid}, 0);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_sel   = 2'b00;
        bus.src1     = 32'hFFFF_FFFE;
        bus.src2     = 32'd3;
        @(negedge clk);
        bus.op_valid = 1'b0;
        #1;
        chk("mw_stall", {bus.stallreq, bus.mul_inb}, {1'b1, 32'd3});
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {bus.stallreq, bus.res_valid, bus.div_start, bus.div_annul}, 0);
        chk("rst_mid_ops", {bus.mul_ina, bus.mul_inb}, 0);
        chk("rst_mid_hilo", {bus.hi_wdata, bus.lo_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            #1;
            seen |= bus.res_valid | bus.stallreq;
            @(negedge clk);
        end
        chk("rst_after", seen, 0);
        run_op(v[4], st, sr, res, got);
        chk("recover_hilo", {63'(got), res}, {1'b1, 32'd2, 32'd14});
        chk("recover_stall", 64'(st), 64'(DS));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 1, meaning the fixed cycle count from mul operand presentation to a valid mul_result (range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port flush, input, 1, pipeline flush caused by an exception or eret.
REQ-005 SHALL have port hold, input, 1, downstream stall: EX may not hand its result to MEM this cycle.
REQ-006 SHALL have port op_valid, input, 1, EX holds a live mul/mulu/div/divu instruction.
REQ-007 SHALL have port op_sel, input, 2, 00 mulu, 01 mul, 10 divu, 11 div.
REQ-008 SHALL have ports src1 and src2, input, 32 each, rs and rt operands.
REQ-009 SHALL have ports mul_ina and mul_inb, output, 32 each, plus mul_signed, output, 1; and mul_result, input, 64.
REQ-010 SHALL have ports div_opdata1 and div_opdata2, output, 32 each, plus div_start, div_signed and div_annul, output, 1 each; and div_ready, input, 1, and div_result, input, 64.
REQ-011 SHALL have port stallreq, output, 1, a stall request into the stall controller.
REQ-012 SHALL have ports res_valid, output, 1, and hi_wdata and lo_wdata, output, 32 each.

Function
REQ-013 SHALL implement the states IDLE, MUL_WAIT, DIV_BUSY and DONE.
REQ-014 In IDLE with op_valid=1 and flush=0, SHALL latch src1, src2 and op_sel into operand registers, assert stallreq combinationally in that same cycle, and move to MUL_WAIT if op_sel[1]=0, otherwise to DIV_BUSY.
REQ-015 SHALL drive mul_ina, mul_inb and mul_signed=op_sel[0] from the operand registers, and the divider operands and div_signed=op_sel[0] from the operand registers.
REQ-016 In MUL_WAIT, SHALL load a 3-bit counter with MUL_LAT-1 on entry, decrement it once per cycle, and capture mul_result into {hi,lo} and move to DONE when the counter reads 0.
REQ-017 In DIV_BUSY, SHALL hold div_start=1 until the cycle in which div_ready=1, then capture div_result into {hi,lo}, drop div_start and move to DONE.
REQ-018 SHALL hold stallreq=1 in MUL_WAIT and DIV_BUSY, and stallreq=0 in DONE and in IDLE when no operation is being accepted.
REQ-019 In DONE, SHALL drive res_valid=1 with hi_wdata/lo_wdata equal to the captured {hi,lo}; SHALL stay in DONE while hold=1; SHALL return to IDLE in the first cycle with hold=0.
REQ-020 SHALL not accept a new op_valid in DONE, and SHALL accept one no earlier than the IDLE cycle that follows.
REQ-021 flush=1 in any state SHALL force IDLE on the next edge, drop stallreq in the same cycle, pulse div_annul=1 for that cycle if the state is DIV_BUSY, and leave res_valid=0 on the next cycle.
REQ-022 Total EX occupancy SHALL be MUL_LAT+1 cycles for mul, and N+1 cycles for div where N is the number of cycles until div_ready.
REQ-023 Outputs SHALL be zero whenever not valid: hi_wdata, lo_wdata and res_valid zero outside DONE, and div_start and div_annul zero outside the conditions given above.

Reset
REQ-024 rst=1 SHALL asynchronously force IDLE, clear the operand registers, the counter and {hi,lo}, and drive stallreq, res_valid, div_start and div_annul to 0.
REQ-025 rst asserted mid-operation SHALL abandon the operation with no residual output after release.

Configuration
REQ-026 With the macro DIV_ZERO_BYPASS_EN defined, a div or divu whose src2 is 0 SHALL skip DIV_BUSY, never assert div_start, and enter DONE one cycle after acceptance with hi=src1 and lo=32'hFFFFFFFF.
REQ-027 Without DIV_ZERO_BYPASS_EN, divide-by-zero SHALL be sequenced through DIV_BUSY exactly like any other division.

Verification
REQ-028 mul with src1=32'hFFFFFFFE, src2=3, MUL_LAT=1 -> stallreq is high for 2 cycles, then res_valid=1 with hi=32'hFFFFFFFF and lo=32'hFFFFFFFA.
REQ-029 divu with src1=100, src2=7, and a divider model that raises div_ready after 33 cycles -> div_start is high for 33 cycles, then DONE with hi=2 and lo=14.
REQ-030 flush in the 10th DIV_BUSY cycle -> a one-cycle div_annul pulse, stallreq=0 in that same cycle, IDLE next cycle, and res_valid never asserted.
REQ-031 hold=1 for 3 cycles while in DONE -> res_valid and {hi,lo} stay stable for 3 cycles, then IDLE.
REQ-032 DIV_ZERO_BYPASS_EN defined, div with src1=5, src2=0 -> no div_start, and DONE one cycle after acceptance with hi=5 and lo=32'hFFFFFFFF.
REQ-033 rst pulsed while in MUL_WAIT -> all outputs are 0 immediately and the state is IDLE after release.
